bnn_fc_seq: RTL and testbench
=============================

Name: bnn_fc_seq

Overview:
- Time-multiplexed binary fully-connected layer: XNOR-popcount of a latched input vector against N_OUT binary weight rows, plus a per-neuron signed bias.
- Successor to the single-shot fully_connected block. Adds:
  - parametrised width, chunking and neuron count;
  - valid/ready handshakes on input and output;
  - a ±1 (signed dot-product) mode;
  - saturation.
- Sits between the binarised feature stage and the classifier argmax.

Parameters:
- N_IN, 960, input vector width in bits; must be a multiple of CHUNK.
- N_OUT, 10, number of output neurons.
- CHUNK, 64, input bits processed per cycle per neuron.
- BIAS_W, 8, bias width, signed two's complement.
- OUT_W, 17, result width, signed two's complement.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fan_in and mode are valid.
- in_ready  out  1  block can accept a vector.
- fan_in  in  N_IN  binary input vector; bit i pairs with weight bit i.
- mode  in  1  0 = raw popcount, 1 = signed score 2*pop - N_IN.
- binary_weights  in  [N_OUT][N_IN]  weight rows. Quasi-static: must be held stable from accept until out_valid.
- bias  in  [N_OUT][BIAS_W]  signed per-neuron bias. Same stability rule as binary_weights.
- out_valid  out  1  fan_out and act_out are valid.
- out_ready  in  1  consumer accepts the result.
- fan_out  out  [N_OUT][OUT_W]  signed saturated results.
- act_out  out  N_OUT  sign activation: bit j = (fan_out[j] >= 0).
- sat_flag  out  1  at least one neuron saturated in the current result.

Behaviour:
- NCHUNK = N_IN/CHUNK. Chunk k covers bits [k*CHUNK+CHUNK-1 : k*CHUNK].
- Internal accumulator width ACC_W = OUT_W+2, signed.
- FSM states: IDLE, ACCUM, BIAS, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready: latch fan_in and mode, clear all acc[j], k=0, go to ACCUM.
  - ACCUM: acc[j] += popcount(~(fan_in_q[chunk k] ^ binary_weights[j][chunk k])) for all j in parallel. k increments; after k = NCHUNK-1, go to BIAS. Takes exactly NCHUNK cycles.
  - BIAS: s = (mode_q ? 2*acc[j] - N_IN : acc[j]) + sign-extended bias[j]. s is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and registered into fan_out[j]. sat_flag = OR of the per-neuron clip events. Go to DONE.
  - DONE: out_valid=1. fan_out, act_out and sat_flag are held stable while out_valid && !out_ready.
- Latency: out_valid rises NCHUNK+1 cycles after the accept edge (16 cycles at default parameters).
- in_ready = (state==IDLE) || (state==DONE && out_ready).
  - If a result is consumed and a new vector is offered in the same cycle, the new vector is accepted and the FSM goes DONE→ACCUM directly. No bubble.
- in_valid in ACCUM/BIAS/DONE (without out_ready) is ignored. fan_in may change freely after accept.
- Reset, at any time including mid-ACCUM: state=IDLE, acc=0, fan_out=0, act_out=0, sat_flag=0, out_valid=0, in_ready=1 (combinational from IDLE). Partial work is discarded; no output is produced for the interrupted vector.
- In mode 0, negative results can occur only through a negative bias.
- Parameter violations (N_IN % CHUNK != 0, or CHUNK > N_IN) are reported by an elaboration-time $error.

Decomposition:
- Package bnn_fc_pkg:
  - fsm state enum;
  - popcount function;
  - saturating-resize function (ACC_W → OUT_W);
  - localparam helpers for NCHUNK and chunk-counter width ($clog2).
- Sub-module xnor_popcount:
  - parameter CHUNK;
  - combinational XNOR plus popcount, output width $clog2(CHUNK+1);
  - instantiated N_OUT times.

Test Plan:
- Defaults; fan_in all 1, all weights all 1, bias 0, mode 0 → fan_out[j]=960, act_out=10'h3FF, out_valid at accept+16. Same with mode 1 → 960.
- Weights = ~fan_in, bias[3] = -5:
  - mode 0 → fan_out=0 except fan_out[3]=-5, act_out[3]=0;
  - mode 1 → fan_out=-960, fan_out[3]=-965.
- fan_in = alternating 1010…, weight row j = first 96*j bits matching fan_in and rest inverted, mode 1, bias 0 → fan_out[j] = 192*j - 960 (e.g. j=0 → -960, j=5 → 0, j=9 → 768).
- Backpressure: out_ready held low 3 cycles → fan_out stable, in_ready=0. Then out_ready=1 together with in_valid=1 → new vector accepted that cycle, next result at +16.
- Assert rst during the 7th ACCUM cycle → next cycle out_valid=0, in_ready=1, fan_out=0. A fresh vector then yields the correct result.
- N_IN=16, CHUNK=4, OUT_W=5, all match, mode 0, bias=+20 → 36 saturates to 15, sat_flag=1. Bias=-20 → -4, sat_flag=0.

Source files
------------

// File: rtl/bnn_fc_pkg.sv
// Shared types and helpers for the sequential binary fully-connected layer.
package bnn_fc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_BIAS  = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_t;

    // Widest chunk the popcount helper accepts; wider chunks are rejected at elaboration.
    localparam int POP_MAX_W = 256;
    // Working width for bias/scale/saturation arithmetic; wide enough that nothing wraps.
    localparam int SAT_W = 64;

    function automatic int nchunk(input int n_in, input int chunk);
        return n_in / chunk;
    endfunction

    // Counter width that still works for a single-chunk configuration.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            cnt = cnt + {31'd0, v[i]};
        end
        return cnt;
    endfunction

    // Clamp a wide signed value into the signed range of out_w bits.
    function automatic logic signed [SAT_W-1:0] sat_resize(input logic signed [SAT_W-1:0] v,
                                                           input int out_w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/bnn_fc_seq_if.sv
// Handshake and data bus between a producer/consumer and bnn_fc_seq.
interface bnn_fc_seq_if #(
    parameter int N_IN  = 960,
    parameter int N_OUT = 10,
    parameter int OUT_W = 17
);
    logic                        in_valid;
    logic                        in_ready;
    logic [N_IN-1:0]             fan_in;
    logic                        mode;
    logic                        out_valid;
    logic                        out_ready;
    logic [N_OUT-1:0][OUT_W-1:0] fan_out;
    logic [N_OUT-1:0]            act_out;
    logic                        sat_flag;

    modport master (
        output in_valid, fan_in, mode, out_ready,
        input  in_ready, out_valid, fan_out, act_out, sat_flag
    );

    modport slave (
        input  in_valid, fan_in, mode, out_ready,
        output in_ready, out_valid, fan_out, act_out, sat_flag
    );
endinterface

// File: rtl/bnn_fc_seq_xnor_popcount.sv
// Combinational XNOR match count of one chunk of input against one chunk of weights.
module xnor_popcount
    import bnn_fc_pkg::*;
#(
    parameter  int CHUNK = 64,
    localparam int CNT_W = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic [CNT_W-1:0] cnt
);
    if (CHUNK > POP_MAX_W) begin : g_chunk_check
        $error("xnor_popcount: CHUNK exceeds POP_MAX_W");
    end

    logic [POP_MAX_W-1:0] match;

    // Matching bits are ones; the unused upper part of the helper input stays zero.
    always_comb begin
        match            = '0;
        match[CHUNK-1:0] = ~(a ^ b);
        cnt              = CNT_W'(popcount(match));
    end
endmodule

// File: rtl/bnn_fc_seq.sv
// Time-multiplexed binary FC layer: per-chunk XNOR-popcount accumulation,
// optional +-1 rescale, signed bias, saturation and sign activation.
module bnn_fc_seq
    import bnn_fc_pkg::*;
#(
    parameter int N_IN   = 960,
    parameter int N_OUT  = 10,
    parameter int CHUNK  = 64,
    parameter int BIAS_W = 8,
    parameter int OUT_W  = 17
) (
    input  logic                         clk,
    input  logic                         rst,
    bnn_fc_seq_if.slave                  bus,
    input  logic [N_OUT-1:0][N_IN-1:0]   binary_weights,
    input  logic [N_OUT-1:0][BIAS_W-1:0] bias
);
    localparam int NCHUNK = nchunk(N_IN, CHUNK);
    localparam int K_W    = cnt_width(NCHUNK);
    localparam int PC_W   = $clog2(CHUNK + 1);
    localparam int ACC_W  = OUT_W + 2;
    localparam logic [K_W-1:0] K_LAST = K_W'(NCHUNK - 1);

    if ((N_IN % CHUNK) != 0 || CHUNK > N_IN) begin : g_param_check
        $error("bnn_fc_seq: N_IN must be a non-zero multiple of CHUNK");
    end

    fsm_state_t       state;
    fsm_state_t       state_next;
    logic             accept;
    logic [K_W-1:0]   k;
    logic [N_IN-1:0]  fan_in_q;
    logic             mode_q;
    logic [N_OUT-1:0] clip;
    logic             sat_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs; DONE can hand over straight to ACCUM.
    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (k == K_LAST) begin
                    state_next = ST_BIAS;
                end
            end
            ST_BIAS: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                bus.in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    state_next = bus.in_valid ? ST_ACCUM : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        accept = bus.in_valid && bus.in_ready;
    end

    // Latch the vector on accept and walk the chunk index during ACCUM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k        <= '0;
            fan_in_q <= '0;
            mode_q   <= 1'b0;
        end else if (accept) begin
            k        <= '0;
            fan_in_q <= bus.fan_in;
            mode_q   <= bus.mode;
        end else if (state == ST_ACCUM && k != K_LAST) begin
            k <= k + 1'b1;
        end
    end

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_neuron
        logic [PC_W-1:0]         pop;
        logic signed [ACC_W-1:0] acc;
        logic signed [SAT_W-1:0] s_ext;
        logic signed [SAT_W-1:0] s_sat;
        logic [OUT_W-1:0]        res;
        logic                    clip_n;
        logic [OUT_W-1:0]        out_q;
        logic                    act_q;

        xnor_popcount #(.CHUNK(CHUNK)) u_pop (
            .a   (fan_in_q[k*CHUNK +: CHUNK]),
            .b   (binary_weights[gi][k*CHUNK +: CHUNK]),
            .cnt (pop)
        );

        // Match-count accumulator, cleared whenever a new vector is taken.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc <= '0;
            end else if (accept) begin
                acc <= '0;
            end else if (state == ST_ACCUM) begin
                acc <= acc + $signed(ACC_W'(pop));
            end
        end

        // Score, bias and clamp in a wide signed domain; clip is any change by the clamp.
        always_comb begin
            s_ext = {{(SAT_W-ACC_W){acc[ACC_W-1]}}, acc};
            if (mode_q) begin
                s_ext = (s_ext <<< 1) - SAT_W'(N_IN);
            end
            s_ext  = s_ext + {{(SAT_W-BIAS_W){bias[gi][BIAS_W-1]}}, bias[gi]};
            s_sat  = sat_resize(s_ext, OUT_W);
            clip_n = (s_sat != s_ext);
            res    = s_sat[OUT_W-1:0];
        end

        // Result register, written only in BIAS so it holds through DONE.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_q <= '0;
                act_q <= 1'b0;
            end else if (state == ST_BIAS) begin
                out_q <= res;
                act_q <= ~res[OUT_W-1];
            end
        end

        assign clip[gi]        = clip_n;
        assign bus.fan_out[gi] = out_q;
        assign bus.act_out[gi] = act_q;
    end

    // Saturation summary for the result being registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (state == ST_BIAS) begin
            sat_q <= |clip;
        end
    end

    assign bus.sat_flag = sat_q;
endmodule

// File: tb/tb_bnn_fc_seq.sv
// Bench for bnn_fc_seq: default-size instance driven from a vector table with a
// scoreboard monitor, plus a small instance for saturation corners.
module tb_bnn_fc_seq;
    localparam int N_IN   = 960;
    localparam int N_OUT  = 10;
    localparam int CHUNK  = 64;
    localparam int BIAS_W = 8;
    localparam int OUT_W  = 17;
    localparam int LAT    = 16;
    localparam int SN_IN  = 16;
    localparam int SN_OUT = 2;
    localparam int SCHUNK = 4;
    localparam int SOUT_W = 5;

    typedef struct packed {
        logic [1:0]                  pat;
        logic                        mode;
        logic signed [BIAS_W-1:0]    b3;
        logic [N_OUT-1:0][OUT_W-1:0] exp;
        logic [N_OUT-1:0]            act;
    } vec_t;

    typedef struct packed {
        logic [N_OUT-1:0][OUT_W-1:0] exp;
        logic [N_OUT-1:0]            act;
        logic                        sat;
        int                          acc_cyc;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   ntx = 0;
    sb_t  sb_q[$];
    vec_t vt[7];

    logic [N_OUT-1:0][N_IN-1:0]    w;
    logic [N_OUT-1:0][BIAS_W-1:0]  b;
    logic [SN_OUT-1:0][SN_IN-1:0]  sw;
    logic [SN_OUT-1:0][BIAS_W-1:0] sbias;

    bnn_fc_seq_if #(.N_IN(N_IN),  .N_OUT(N_OUT),  .OUT_W(OUT_W))  bus();
    bnn_fc_seq_if #(.N_IN(SN_IN), .N_OUT(SN_OUT), .OUT_W(SOUT_W)) sbus();

    bnn_fc_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .CHUNK(CHUNK), .BIAS_W(BIAS_W), .OUT_W(OUT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .binary_weights (w),
        .bias           (b)
    );

    bnn_fc_seq #(.N_IN(SN_IN), .N_OUT(SN_OUT), .CHUNK(SCHUNK), .BIAS_W(BIAS_W), .OUT_W(SOUT_W)) dut_small (
        .clk            (clk),
        .rst            (rst),
        .bus            (sbus),
        .binary_weights (sw),
        .bias           (sbias)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [N_IN-1:0] pat_fan_in(input int pat);
        logic [N_IN-1:0] v;
        v = '0;
        case (pat)
            0: v = '1;
            1: v = {15{64'hDEADBEEF0123CAFE}};
            2: for (int i = 0; i < N_IN; i++) v[i] = (i % 2 == 1);
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic load_weights(input int pat);
        logic [N_IN-1:0] fi;
        fi = pat_fan_in(pat);
        for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (pat == 0)      w[j][i] = 1'b1;
                else if (pat == 1) w[j][i] = ~fi[i];
                else               w[j][i] = (i < 96 * j) ? fi[i] : ~fi[i];
            end
        end
    endtask

    // Offer table entry idx; returns the cycle stamp of the accepting edge.
    task automatic apply(input int idx, input bit push, output int acc_cyc);
        sb_t e;
        int  n;
        load_weights(int'(vt[idx].pat));
        b           = '0;
        b[3]        = vt[idx].b3;
        bus.fan_in  = pat_fan_in(int'(vt[idx].pat));
        bus.mode    = vt[idx].mode;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        if (push) begin
            e.exp     = vt[idx].exp;
            e.act     = vt[idx].act;
            e.sat     = 1'b0;
            e.acc_cyc = cyc;
            sb_q.push_back(e);
        end
        bus.in_valid = 1'b0;
        bus.fan_in   = {30{$urandom()}};
        bus.mode     = ~bus.mode;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", sb_q.size(), 0);
    endtask

    task automatic small_run(input bit md, input int b0, input int b1,
                             input int e0, input int e1, input bit esat);
        int n;
        int c0;
        sw            = '1;
        sbias[0]      = BIAS_W'(b0);
        sbias[1]      = BIAS_W'(b1);
        sbus.fan_in   = '1;
        sbus.mode     = md;
        sbus.in_valid = 1'b1;
        n = 0;
        while (!sbus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        c0            = cyc;
        sbus.in_valid = 1'b0;
        sbus.fan_in   = '0;
        n = 0;
        while (!sbus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("s_latency", cyc - c0, 5);
        chk("s_fan_out0", $signed(sbus.fan_out[0]), e0);
        chk("s_fan_out1", $signed(sbus.fan_out[1]), e1);
        chk("s_act", sbus.act_out, {31'd0, e1 >= 0, e0 >= 0});
        chk("s_sat", sbus.sat_flag, esat);
        $display("small txn mode=%0b bias=%0d/%0d -> fan_out=%0d/%0d sat=%0b",
                 md, b0, b1, $signed(sbus.fan_out[0]), $signed(sbus.fan_out[1]), sbus.sat_flag);
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: latency on first valid, contents every valid cycle, pop on transfer.
    initial begin
        sb_t e;
        bit  seen;
        seen = 1'b0;
        forever begin
            @(posedge clk); #3;
            if (bus.out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = sb_q[0];
                    if (!seen) begin
                        chk("latency", cyc - e.acc_cyc, LAT);
                        seen = 1'b1;
                    end
                    for (int j = 0; j < N_OUT; j++) begin
                        chk($sformatf("fan_out[%0d]", j), $signed(bus.fan_out[j]), $signed(e.exp[j]));
                    end
                    chk("act_out", bus.act_out, e.act);
                    chk("sat_flag", bus.sat_flag, e.sat);
                    if (bus.out_ready) begin
                        void'(sb_q.pop_front());
                        seen = 1'b0;
                        ntx++;
                        $display("txn %0d: fan_out[0]=%0d fan_out[3]=%0d fan_out[9]=%0d act=%h sat=%0b",
                                 ntx, $signed(bus.fan_out[0]), $signed(bus.fan_out[3]),
                                 $signed(bus.fan_out[9]), bus.act_out, bus.sat_flag);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int ca;

        // Vector table: expected values written from the layer's arithmetic definition.
        for (int i = 0; i < 7; i++) vt[i] = '0;
        vt[0].pat = 2'd0; vt[0].mode = 1'b0; vt[0].b3 = 8'sd0;  vt[0].act = 10'h3FF;
        vt[1].pat = 2'd0; vt[1].mode = 1'b1; vt[1].b3 = 8'sd0;  vt[1].act = 10'h3FF;
        vt[2].pat = 2'd1; vt[2].mode = 1'b0; vt[2].b3 = -8'sd5; vt[2].act = 10'h3F7;
        vt[3].pat = 2'd1; vt[3].mode = 1'b1; vt[3].b3 = -8'sd5; vt[3].act = 10'h000;
        vt[4].pat = 2'd2; vt[4].mode = 1'b1; vt[4].b3 = 8'sd0;  vt[4].act = 10'h3E0;
        vt[5].pat = 2'd2; vt[5].mode = 1'b0; vt[5].b3 = 8'sd0;  vt[5].act = 10'h3FF;
        vt[6].pat = 2'd0; vt[6].mode = 1'b0; vt[6].b3 = -8'sd5; vt[6].act = 10'h3FF;
        for (int j = 0; j < N_OUT; j++) begin
            vt[0].exp[j] = OUT_W'(960);
            vt[1].exp[j] = OUT_W'(960);
            vt[2].exp[j] = OUT_W'(0);
            vt[3].exp[j] = OUT_W'(-960);
            vt[4].exp[j] = OUT_W'(192 * j - 960);
            vt[5].exp[j] = OUT_W'(96 * j);
            vt[6].exp[j] = OUT_W'(960);
        end
        vt[2].exp[3] = OUT_W'(-5);
        vt[3].exp[3] = OUT_W'(-965);
        vt[6].exp[3] = OUT_W'(955);

        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.fan_in     = '0;
        bus.mode       = 1'b0;
        bus.out_ready  = 1'b1;
        sbus.in_valid  = 1'b0;
        sbus.fan_in    = '0;
        sbus.mode      = 1'b0;
        sbus.out_ready = 1'b1;
        w     = '0;
        b     = '0;
        sw    = '0;
        sbias = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_fan_out_zero", (bus.fan_out == '0), 1);
        chk("rst_act_out", bus.act_out, 0);
        chk("rst_sat_flag", bus.sat_flag, 0);
        chk("rst_small_in_ready", sbus.in_ready, 1);

        // Table-driven vectors, one at a time (weights are quasi-static per vector).
        for (int i = 0; i < 6; i++) begin
            apply(i, 1'b1, ca);
            wait_drain();
        end

        // Backpressure: hold the result three cycles, then consume and accept together.
        apply(4, 1'b1, ca);
        bus.out_ready = 1'b0;
        begin
            int n;
            n = 0;
            while (!bus.out_valid && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("bp_out_valid", bus.out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready_low", bus.in_ready, 0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", bus.in_ready, 1);
        c0 = cyc;
        apply(5, 1'b1, ca);
        chk("bp_no_bubble", ca - c0, 1);
        wait_drain();

        // Reset in the 7th ACCUM cycle discards the vector; a fresh one then completes.
        apply(4, 1'b0, ca);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_fan_out_zero", (bus.fan_out == '0), 1);
        chk("mid_rst_act_out", bus.act_out, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("mid_rst_no_output", bus.out_valid, 0);
        apply(6, 1'b1, ca);
        wait_drain();

        // Saturation corners on the small instance.
        small_run(1'b0,  20,  -1, 15,  15, 1'b1);
        small_run(1'b0, -20,  -1, -4,  15, 1'b0);
        small_run(1'b1, -20, -40, -4, -16, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
